// File: rtl/cpu_mux_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_mux_pkg : shared helpers for mux/arbiter blocks (clog2, onehot->index) |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package cpu_mux_pkg;

    localparam int MAX_CH = 32;

    typedef logic [MAX_CH-1:0] ch_vec_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Highest set bit wins; callers pass a one-hot (or zero) vector.
    function automatic int unsigned onehot_to_idx(input ch_vec_t v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx1_rr_reg_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_arbiter : combinational one-hot grant, search starts at ptr and wraps  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant
);

    always_comb begin : p_rotate
        logic             found;
        logic [SEL_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = SEL_W'((int'(ptr) + k) % N_CH);
            if (req[idx] && !found) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_rr_reg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mux_nx1_rr_reg : N-channel registered mux, valid/ready, round-robin select |
// | Option MUX_NX1_RR_FIXED_PRIO_EN: fixed lowest-index priority. Rev 1.0     |
// +---------------------------------------------------------------------------+
module mux_nx1_rr_reg
    import cpu_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 3,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_sel,
    output logic                out_valid,
    input  logic                out_ready
);

    out_state_e       state;
    logic             load;
    logic             xfer;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] xfer_idx;
    ch_vec_t          ready_ext;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign out_valid = (state == ST_FULL);
    assign load      = ~out_valid | out_ready;
    // Ready is forced low while reset is asserted, even before the register clears.
    assign in_ready  = (load && rst_n) ? grant : '0;
    assign xfer      = |(in_valid & in_ready);
    assign ready_ext = ch_vec_t'(in_ready);
    assign xfer_idx  = SEL_W'(onehot_to_idx(ready_ext));

`ifdef MUX_NX1_RR_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [SEL_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (xfer_idx == SEL_W'(N_CH - 1)) ? '0 : xfer_idx + 1'b1;
        end
    end

    assign ptr = rr_ptr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            if (xfer) begin
                out_data <= in_data[xfer_idx*W +: W];
                out_sel  <= xfer_idx;
            end
            case (state)
                ST_EMPTY: if (xfer) state <= ST_FULL;
                ST_FULL:  if (!xfer && out_ready) state <= ST_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire
